// File: rtl/mt_pkg.sv
// mt_pkg: thread/width constants, reset-PC helper and the fetch-to-decode bundle
package mt_pkg;
    localparam int NUM_THREADS = 8;
    localparam int BITS_THREADS = $clog2(NUM_THREADS);
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ADDRESS_WIDTH-1:0] THREAD_PC_OFFSET = 32'h0000_0400;
    typedef logic [BITS_THREADS-1:0] tid_t;
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef struct packed {
        logic  valid;
        tid_t  tid;
        addr_t pc;
        data_t instr;
    } if_bundle_t;
    function automatic addr_t reset_pc(int t);
        return RESET_PC + addr_t'(t) * THREAD_PC_OFFSET;
    endfunction
endpackage

// File: rtl/mt_rr_arbiter.sv
// mt_rr_arbiter: round-robin first-enabled search starting just after last_tid
module mt_rr_arbiter #(
    parameter int NUM_THREADS = 8,
    localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0]  enable,
    input  logic [BITS_THREADS-1:0] last_tid,
    output logic [BITS_THREADS-1:0] grant_tid,
    output logic                    grant_valid
);
    logic [BITS_THREADS-1:0] idx;
    // scan farthest-first so the nearest enabled thread after last_tid wins
    always_comb begin
        grant_tid = last_tid;
        idx = '0;
        for (int i = NUM_THREADS; i >= 1; i--) begin
            idx = last_tid + BITS_THREADS'(i);
            grant_tid = enable[idx] ? idx : grant_tid;
        end
    end
    assign grant_valid = |enable;
endmodule

// File: rtl/mt_fetch.sv
// mt_fetch: barrel-thread fetch, one round-robin thread per cycle into a 1-cycle imem
module mt_fetch
    import mt_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_THREADS-1:0]   thread_enable,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [BITS_THREADS-1:0]  redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     if_valid,
    output logic [BITS_THREADS-1:0]  if_tid,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0]    if_instr
);
    addr_t      pc [NUM_THREADS];
    tid_t       last_tid, sel_tid, f2_tid;
    addr_t      f2_pc;
    data_t      hold_reg;
    logic       any_en, collide, issue, kill, f2_valid, hold_flag;
    if_bundle_t if_bundle;

    mt_rr_arbiter #(.NUM_THREADS(NUM_THREADS)) u_arb (
        .enable      (thread_enable),
        .last_tid    (last_tid),
        .grant_tid   (sel_tid),
        .grant_valid (any_en)
    );

    // a redirect aimed at the selected thread blocks its issue so it refetches at the new PC
    assign collide = redirect_valid && redirect_tid == sel_tid;
    assign issue = rst_n && !stall && any_en && !collide;
    assign kill = redirect_valid && f2_valid && f2_tid == redirect_tid;
    assign imem_req = issue;
    assign imem_addr = issue ? pc[sel_tid] : '0;

    assign if_bundle = '{valid: f2_valid, tid: f2_tid, pc: f2_pc, instr: hold_flag ? hold_reg : imem_rdata};
    assign if_valid = if_bundle.valid;
    assign if_tid = if_bundle.tid;
    assign if_pc = if_bundle.pc;
    assign if_instr = if_bundle.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) pc[t] <= reset_pc(t);
            last_tid <= tid_t'(NUM_THREADS - 1);
            f2_valid <= 1'b0;
            f2_tid <= '0;
            f2_pc <= '0;
            hold_reg <= '0;
            hold_flag <= 1'b0;
        end else begin
            if (issue) begin
                pc[sel_tid] <= pc[sel_tid] + ADDRESS_WIDTH'(4);
                last_tid <= sel_tid;
                f2_tid <= sel_tid;
                f2_pc <= pc[sel_tid];
            end
            if (redirect_valid) pc[redirect_tid] <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            f2_valid <= stall ? f2_valid && !kill : issue;
            // imem_rdata only lives one cycle, so capture it on stall entry
            hold_flag <= stall;
            if (stall && !hold_flag) hold_reg <= imem_rdata;
        end
    end
endmodule

// File: doc/mt_fetch.md
Name: mt_fetch

Overview:
Barrel-thread fetch stage that sits directly upstream of decode. It holds one PC per hardware thread and picks one enabled thread per cycle in round-robin order. It sends that thread's PC to a synchronous instruction memory and presents {tid, pc, instr} to decode; decode uses the tid as the register-file read thread.
Thread redirects from execute (branch, jump) rewrite per-thread PCs and squash stale fetches.

Parameters:
NUM_THREADS, 8, number of hardware threads (power of two)
BITS_THREADS, $clog2(NUM_THREADS), thread-id width
ADDRESS_WIDTH, 32, PC / instruction address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, reset PC of thread 0
THREAD_PC_OFFSET, 32'h0000_0400, reset PC spacing between threads

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
thread_enable  in  NUM_THREADS  bit t=1 makes thread t eligible for fetch
stall  in  1  decode not accepting; hold output stage
redirect_valid  in  1  PC rewrite request from execute
redirect_tid  in  BITS_THREADS  thread being redirected
redirect_pc  in  ADDRESS_WIDTH  new PC for redirect_tid
imem_req  out  1  instruction-memory read strobe
imem_addr  out  ADDRESS_WIDTH  read address; data returns on imem_rdata next cycle
imem_rdata  in  DATA_WIDTH  instruction data, valid the cycle after imem_req
if_valid  out  1  output bundle valid
if_tid  out  BITS_THREADS  thread id of the output instruction
if_pc  out  ADDRESS_WIDTH  PC of the output instruction
if_instr  out  DATA_WIDTH  instruction word

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc[t] = RESET_PC + t*THREAD_PC_OFFSET.
  - last_tid = NUM_THREADS-1, so the first issue is tid 0 if enabled.
  - if_valid=0; if_tid, if_pc, hold register and hold flag = 0.
  - imem_req=0 while in reset.
- Select (F1), combinational:
  - sel_tid is the first enabled thread scanning last_tid+1, last_tid+2, ..., wrapping modulo NUM_THREADS.
  - With a single enabled thread, sel_tid repeats every cycle.
  - No enabled thread: no issue.
- Issue condition: stall==0, at least one thread enabled, and NOT (redirect_valid and redirect_tid==sel_tid).
- On issue:
  - imem_req=1 and imem_addr=pc[sel_tid].
  - pc[sel_tid] <= pc[sel_tid]+4, wrapping modulo 2^ADDRESS_WIDTH.
  - last_tid <= sel_tid.
  - F2 regs <= {valid=1, sel_tid, pc}.
- Not issued and stall==0: F2 valid <= 0 (bubble). If the block was due to a redirect collision, last_tid is not advanced, so the same thread is reselected next cycle at its new PC.
- Redirect:
  - pc[redirect_tid] <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - Redirect takes priority over the +4 update.
  - If the F2 entry is valid with tid==redirect_tid, if_valid is cleared at the next edge. This applies while stalled too.
- Output (F2):
  - if_valid, if_tid and if_pc are registered.
  - if_instr = hold_flag ? hold_reg : imem_rdata.
  - Fetch-to-decode latency is 1 cycle: issue in cycle N gives if_valid in cycle N+1.
- Stall:
  - stall=1 forces imem_req=0; the pc array and last_tid are unchanged; F2 registers hold.
  - First stall cycle with hold_flag=0: hold_reg <= imem_rdata, hold_flag <= 1.
  - hold_flag clears on the first non-stall edge. Outputs stay stable for the whole stall, regardless of imem_rdata changes.
- Simultaneous events:
  - Redirect + stall: the PC is written and F2 is killed if its tid matches; no issue.
  - thread_enable changes take effect on the next select. A thread disabled while its instruction is in F2 still completes.
- imem_addr = 0 when imem_req=0.

Decomposition:
- Shared package mt_pkg holds:
  - NUM_THREADS, BITS_THREADS, ADDRESS_WIDTH, DATA_WIDTH and the reset-PC constants, which mt_reg_file also uses.
  - A fetch-to-decode bundle typedef {valid, tid, pc, instr}.
- One sub-module, mt_rr_arbiter: a round-robin first-set-bit search over thread_enable starting at last_tid+1. It is purely combinational, and parameterised by NUM_THREADS.

Test Plan:
1. Reset, all 8 enabled, no stall → if_tid 0,1,...,7,0 on consecutive cycles. if_pc 0x000,0x400,...,0x1C00, then 0x004 for thread 0 on the second pass.
2. thread_enable=8'b0000_0101 → if_tid 0,2,0,2. Thread 0 pcs 0x000,0x004; thread 2 pcs 0x800,0x804. Thread 1 pc[1] stays 0x400.
3. Stall held 3 cycles while imem_rdata changes 0xAAAA_AAAA→0x5555_5555 → if_valid, if_tid, if_pc and if_instr (0xAAAA_AAAA) stable. imem_req=0 throughout; the stream resumes with the next tid after release.
4. redirect_valid with redirect_tid=sel_tid=3, redirect_pc=0x1003 → no issue that cycle (bubble). The next cycle fetches tid 3 at imem_addr 0x1000.
5. Single enabled thread 5; redirect tid 5 while its fetch sits in F2 → that entry's if_valid drops. The next tid 5 fetch uses the redirect PC.
6. thread_enable=0 → imem_req=0, if_valid=0. Asserting rst_n low mid-stream clears if_valid immediately (asynchronously) and restores all reset PCs.
